// File: rtl/writeback_arb_q_pkg.sv
// Shared writeback definitions: request record, default source count and the
// fixed source slot assignment used by the execute/LSU/M-ext units.
package writeback_arb_q_pkg;

  localparam int WRB_XLEN    = 32;
  localparam int WRB_RADDR_W = 5;
  localparam int WRB_NUM_SRC = 4;

  localparam int WRB_SRC_ALU = 0;
  localparam int WRB_SRC_LSU = 0;  // ALU and LSU share a port upstream
  localparam int WRB_SRC_CSR = 1;
  localparam int WRB_SRC_MUL = 2;
  localparam int WRB_SRC_DIV = 3;

  typedef struct packed {
    logic [WRB_RADDR_W-1:0] rd_addr;
    logic [WRB_XLEN-1:0]    rd_data;
  } type_wrb_req_s;

  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/writeback_arb_q_rr_arbiter.sv
// One-hot request arbiter: rotating priority starting at ptr_reg, or fixed
// priority (index 0 highest) when RR_EN is 0.
module wrb_rr_arbiter
  import writeback_arb_q_pkg::*;
#(
  parameter int NUM_SRC = WRB_NUM_SRC,
  parameter int RR_EN   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_SRC-1:0] grant_o
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    winner  = '0;
    cand    = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = (RR_EN != 0) ? PW'(wrap_idx(int'(ptr_reg) + off, NUM_SRC)) : PW'(off);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        winner        = cand;
      end
    end
  end

  // Pointer moves past the winner only when the grant actually transferred.
  always_comb begin
    ptr_next = ptr_reg;
    if (advance_i) begin
      ptr_next = (winner == PW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/writeback_arb_q.sv
// Writeback stage: arbitrates result producers into a small in-order queue that
// drains to the register-file write port and answers operand-forwarding lookups.
module writeback_arb_q
  import writeback_arb_q_pkg::*;
#(
  parameter int XLEN       = WRB_XLEN,
  parameter int NUM_SRC    = WRB_NUM_SRC,
  parameter int RADDR_W    = WRB_RADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RR_EN      = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  input  logic [NUM_SRC*RADDR_W-1:0]    src_rd_addr_i,
  input  logic [NUM_SRC*XLEN-1:0]       src_rd_data_i,
  output logic                          rf_wr_req_o,
  input  logic                          rf_wr_ready_i,
  output logic [RADDR_W-1:0]            rf_wr_addr_o,
  output logic [XLEN-1:0]               rf_wr_data_o,
  input  logic [2*RADDR_W-1:0]          fwd_rs_addr_i,
  output logic [1:0]                    fwd_hit_o,
  output logic [2*XLEN-1:0]             fwd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   q_count_o,
  output logic                          q_empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [RADDR_W-1:0] q_addr_reg [FIFO_DEPTH];
  logic [XLEN-1:0]    q_data_reg [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;

  logic [NUM_SRC-1:0] grant;
  logic               can_accept;
  logic               xfer;
  logic               enq;
  logic               deq;
  logic [RADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]    sel_data;

  wrb_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .RR_EN   (RR_EN)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (src_valid_i),
    .advance_i (xfer),
    .grant_o   (grant)
  );

  // A slot frees up in the same cycle as a dequeue, so full+deq still accepts.
  assign rf_wr_req_o = rst_n && (count_reg != '0);
  assign deq         = rf_wr_req_o && rf_wr_ready_i;
  assign can_accept  = (count_reg < CW'(FIFO_DEPTH)) || deq;
  assign xfer        = rst_n && (|grant) && can_accept;
  assign src_ready_o = xfer ? grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant[s]) begin
        sel_addr = sel_addr | src_rd_addr_i[s*RADDR_W +: RADDR_W];
        sel_data = sel_data | src_rd_data_i[s*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 complete the handshake but never occupy a queue slot.
  assign enq = xfer && (sel_addr != '0);

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr_reg[wr_ptr_reg] <= sel_addr;
      q_data_reg[wr_ptr_reg] <= sel_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign rf_wr_addr_o = q_addr_reg[rd_ptr_reg];
  assign rf_wr_data_o = q_data_reg[rd_ptr_reg];
  assign q_count_o    = count_reg;
  assign q_empty_o    = (count_reg == '0);

  // Scan oldest to youngest so the last match left standing is the youngest.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [RADDR_W-1:0] rs;
    logic [PW-1:0]      fidx;
    logic               hit;
    logic [XLEN-1:0]    data;

    assign rs = fwd_rs_addr_i[gi*RADDR_W +: RADDR_W];

    always_comb begin
      hit  = 1'b0;
      data = '0;
      fidx = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fidx = rd_ptr_reg + PW'(i);
        if ((CW'(i) < count_reg) && (rs != '0) && (q_addr_reg[fidx] == rs)) begin
          hit  = 1'b1;
          data = q_data_reg[fidx];
        end
      end
    end

    assign fwd_hit_o[gi]               = hit;
    assign fwd_data_o[gi*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_writeback_arb_q.sv
// Directed bench for writeback_arb_q: table-driven fill/drain plus hand-written
// latency, x0, forwarding, reset and arbitration-order sequences.
module tb_writeback_arb_q;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   src_valid;
  logic [19:0]  src_rd_addr;
  logic [127:0] src_rd_data;
  logic         rf_wr_ready;
  logic [9:0]   fwd_rs_addr;

  logic [3:0]   src_ready,   src_ready2;
  logic         rf_wr_req,   rf_wr_req2;
  logic [4:0]   rf_wr_addr,  rf_wr_addr2;
  logic [31:0]  rf_wr_data,  rf_wr_data2;
  logic [1:0]   fwd_hit,     fwd_hit2;
  logic [63:0]  fwd_data,    fwd_data2;
  logic [2:0]   q_count,     q_count2;
  logic         q_empty,     q_empty2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_arb_q #(.XLEN(32), .NUM_SRC(4), .RADDR_W(5), .FIFO_DEPTH(4), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_rd_addr_i(src_rd_addr), .src_rd_data_i(src_rd_data),
    .rf_wr_req_o(rf_wr_req), .rf_wr_ready_i(rf_wr_ready),
    .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data),
    .fwd_rs_addr_i(fwd_rs_addr), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .q_count_o(q_count), .q_empty_o(q_empty)
  );

  writeback_arb_q #(.XLEN(32), .NUM_SRC(4), .RADDR_W(5), .FIFO_DEPTH(4), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready2),
    .src_rd_addr_i(src_rd_addr), .src_rd_data_i(src_rd_data),
    .rf_wr_req_o(rf_wr_req2), .rf_wr_ready_i(rf_wr_ready),
    .rf_wr_addr_o(rf_wr_addr2), .rf_wr_data_o(rf_wr_data2),
    .fwd_rs_addr_i(fwd_rs_addr), .fwd_hit_o(fwd_hit2), .fwd_data_o(fwd_data2),
    .q_count_o(q_count2), .q_empty_o(q_empty2)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic [2:0]  exp_cnt;
    logic        exp_req;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [4:0] rd, input logic [31:0] d);
    src_valid = v;
    for (int s = 0; s < 4; s++) begin
      src_rd_addr[s*5 +: 5]   = rd;
      src_rd_data[s*32 +: 32] = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill four entries with the queue blocked, stall a fifth, then drain in order.
    vecs[0]  = '{4'b0001, 5'd1, 32'hA, 1'b0, 4'b0001, 3'd0, 1'b0, 5'd0, 32'h0};
    vecs[1]  = '{4'b0010, 5'd2, 32'hB, 1'b0, 4'b0010, 3'd1, 1'b1, 5'd1, 32'hA};
    vecs[2]  = '{4'b0100, 5'd3, 32'hC, 1'b0, 4'b0100, 3'd2, 1'b1, 5'd1, 32'hA};
    vecs[3]  = '{4'b1000, 5'd4, 32'hD, 1'b0, 4'b1000, 3'd3, 1'b1, 5'd1, 32'hA};
    vecs[4]  = '{4'b0001, 5'd5, 32'hE, 1'b0, 4'b0000, 3'd4, 1'b1, 5'd1, 32'hA};
    vecs[5]  = '{4'b0001, 5'd5, 32'hE, 1'b1, 4'b0001, 3'd4, 1'b1, 5'd1, 32'hA};
    vecs[6]  = '{4'b0000, 5'd0, 32'h0, 1'b1, 4'b0000, 3'd4, 1'b1, 5'd2, 32'hB};
    vecs[7]  = '{4'b0000, 5'd0, 32'h0, 1'b1, 4'b0000, 3'd3, 1'b1, 5'd3, 32'hC};
    vecs[8]  = '{4'b0000, 5'd0, 32'h0, 1'b1, 4'b0000, 3'd2, 1'b1, 5'd4, 32'hD};
    vecs[9]  = '{4'b0000, 5'd0, 32'h0, 1'b1, 4'b0000, 3'd1, 1'b1, 5'd5, 32'hE};
    vecs[10] = '{4'b0000, 5'd0, 32'h0, 1'b1, 4'b0000, 3'd0, 1'b0, 5'd0, 32'h0};

    rst_n       = 1'b0;
    rf_wr_ready = 1'b0;
    fwd_rs_addr = '0;
    drive(4'b0000, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk("init_empty", 32'(q_empty), 32'd1);
    chk("init_req",   32'(rf_wr_req), 32'd0);
    chk("init_count", 32'(q_count), 32'd0);
    chk("init_hit",   32'(fwd_hit), 32'd0);
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].data);
      rf_wr_ready = vecs[i].rdy;
      #3;
      chk($sformatf("vec%0d_ready", i), 32'(src_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_count", i), 32'(q_count),   32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_req", i),   32'(rf_wr_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        chk($sformatf("vec%0d_addr", i), 32'(rf_wr_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_data", i), rf_wr_data, vecs[i].exp_data);
      end
      tick();
    end

    // Latency: enqueue x1=0xA, write appears on the RF port the next cycle.
    rf_wr_ready = 1'b1;
    drive(4'b0010, 5'd1, 32'hA);
    #3;
    chk("lat_ready", 32'(src_ready), 32'b0010);
    chk("lat_req_before", 32'(rf_wr_req), 32'd0);
    tick();
    drive(4'b0000, 5'd0, 32'h0);
    #3;
    chk("lat_req", 32'(rf_wr_req), 32'd1);
    chk("lat_addr", 32'(rf_wr_addr), 32'd1);
    chk("lat_data", rf_wr_data, 32'hA);
    tick();
    #3;
    chk("lat_drained", 32'(q_count), 32'd0);
    tick();

    // x0 write: handshake completes, nothing enqueued.
    drive(4'b0100, 5'd0, 32'hDEAD);
    #3;
    chk("x0_ready", 32'(src_ready), 32'b0100);
    tick();
    drive(4'b0000, 5'd0, 32'h0);
    #3;
    chk("x0_count", 32'(q_count), 32'd0);
    chk("x0_req", 32'(rf_wr_req), 32'd0);
    tick();

    // Forwarding: x5=0x11 then x5=0x22, lookups on x5 and x0.
    rf_wr_ready = 1'b0;
    fwd_rs_addr = {5'd0, 5'd5};
    drive(4'b1000, 5'd5, 32'h11);
    #3;
    chk("fwd_ready_a", 32'(src_ready), 32'b1000);
    chk("fwd_hit_empty", 32'(fwd_hit), 32'b00);
    tick();
    drive(4'b0001, 5'd5, 32'h22);
    #3;
    chk("fwd_hit_one", 32'(fwd_hit), 32'b01);
    chk("fwd_data_one", fwd_data[31:0], 32'h11);
    tick();
    drive(4'b0010, 5'd0, 32'hDEAD);
    #3;
    chk("fwd_hit_x0", 32'(fwd_hit), 32'b01);
    chk("fwd_data_young", fwd_data[31:0], 32'h22);
    chk("fwd_count", 32'(q_count), 32'd2);
    tick();
    drive(4'b0000, 5'd0, 32'h0);
    rf_wr_ready = 1'b1;
    #3;
    chk("fwd_count_x0", 32'(q_count), 32'd2);
    chk("fwd_head_data", rf_wr_data, 32'h11);
    chk("fwd_data_deq", fwd_data[31:0], 32'h22);
    tick();
    fwd_rs_addr = {5'd7, 5'd5};
    #3;
    chk("fwd_hit_last", 32'(fwd_hit), 32'b01);
    chk("fwd_data_last", fwd_data[31:0], 32'h22);
    tick();
    #3;
    chk("fwd_hit_gone", 32'(fwd_hit), 32'b00);
    tick();

    // Reset with three queued entries: queue discarded, no write afterwards.
    rf_wr_ready = 1'b0;
    drive(4'b0111, 5'd8, 32'h55);
    repeat (3) tick();
    drive(4'b0000, 5'd0, 32'h0);
    #3;
    chk("rst_pre_count", 32'(q_count), 32'd3);
    tick();
    rst_n = 1'b0;
    rf_wr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #3;
    chk("rst_empty", 32'(q_empty), 32'd1);
    chk("rst_ready", 32'(src_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_req%0d", i), 32'(rf_wr_req), 32'd0);
      tick();
      #3;
    end
    chk("rst_count", 32'(q_count), 32'd0);
    tick();

    // Arbitration order with all sources valid and the RF always ready.
    drive(4'b1111, 5'd9, 32'h77);
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("rr_grant%0d", i), 32'(src_ready), 32'(4'b0001 << (i % 4)));
      chk($sformatf("fp_grant%0d", i), 32'(src_ready2), 32'b0001);
      chk($sformatf("rr_count%0d", i), 32'(q_count), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    drive(4'b0000, 5'd0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
